// File: rtl/result_drain_if.sv
// Readback stream between result_drain and the host path: one result word
// per rvalid/rready handshake, tagged with its index and a last flag.
interface result_drain_if #(
  parameter int DW = 33
);
  logic [DW-1:0] rdata;
  logic [3:0]    raddr;
  logic          rvalid;
  logic          rready;
  logic          rlast;

  modport master (
    output rdata,
    output raddr,
    output rvalid,
    output rlast,
    input  rready
  );

  modport slave (
    input  rdata,
    input  raddr,
    input  rvalid,
    input  rlast,
    output rready
  );
endinterface

// File: rtl/result_drain.sv
// Snapshots the 4x4 array accumulators on done, pulses arr_clr so the array can
// start the next tile, then streams the 16 captured words over the readback stream.
module result_drain #(
  parameter int DW = 33,
  parameter int NW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          done,
  input  logic [DW-1:0] c1,
  input  logic [DW-1:0] c2,
  input  logic [DW-1:0] c3,
  input  logic [DW-1:0] c4,
  input  logic [DW-1:0] c5,
  input  logic [DW-1:0] c6,
  input  logic [DW-1:0] c7,
  input  logic [DW-1:0] c8,
  input  logic [DW-1:0] c9,
  input  logic [DW-1:0] c10,
  input  logic [DW-1:0] c11,
  input  logic [DW-1:0] c12,
  input  logic [DW-1:0] c13,
  input  logic [DW-1:0] c14,
  input  logic [DW-1:0] c15,
  input  logic [DW-1:0] c16,
  result_drain_if.master rd,
  output logic          arr_clr,
  output logic          busy,
  output logic          ovr
);

  localparam int             IW       = 4;
  localparam logic [IW-1:0]  LAST_IDX = IW'(NW - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t          state_r, state_n;
  logic [IW-1:0]   idx_r, idx_n;
  logic            arr_clr_r, arr_clr_n;
  logic            ovr_r, ovr_n;
  logic            capture_s;
  logic [DW-1:0]   c_s    [NW];
  logic [DW-1:0]   bank_r [NW];

  assign c_s = '{c1, c2, c3, c4, c5, c6, c7, c8,
                 c9, c10, c11, c12, c13, c14, c15, c16};

  // Control state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r   <= IDLE;
      idx_r     <= {IW{1'b0}};
      arr_clr_r <= 1'b0;
      ovr_r     <= 1'b0;
    end else begin
      state_r   <= state_n;
      idx_r     <= idx_n;
      arr_clr_r <= arr_clr_n;
      ovr_r     <= ovr_n;
    end
  end

  // Next state; done while a tile is still draining never overwrites the bank
  always_comb begin
    state_n   = state_r;
    idx_n     = idx_r;
    arr_clr_n = 1'b0;
    ovr_n     = ovr_r;
    capture_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (done) begin
          state_n   = SEND;
          idx_n     = {IW{1'b0}};
          arr_clr_n = 1'b1;
          capture_s = 1'b1;
        end else begin
          idx_n     = {IW{1'b0}};
        end
      end
      SEND: begin
        ovr_n = ovr_r | done;
        if (rd.rready) begin
          if (idx_r == LAST_IDX) begin
            state_n = IDLE;
            idx_n   = {IW{1'b0}};
          end else begin
            idx_n   = idx_r + {{(IW-1){1'b0}}, 1'b1};
          end
        end else begin
          idx_n = idx_r;
        end
      end
      default: begin
        state_n = IDLE;
        idx_n   = {IW{1'b0}};
      end
    endcase
  end

  // Snapshot bank, bit-exact copy of the array outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NW; i++) begin
        bank_r[i] <= {DW{1'b0}};
      end
    end else if (capture_s) begin
      bank_r <= c_s;
    end
  end

  // Stream outputs decoded from registered state; zero whenever not valid
  always_comb begin
    rd.rvalid = 1'b0;
    rd.rdata  = {DW{1'b0}};
    rd.raddr  = {IW{1'b0}};
    rd.rlast  = 1'b0;
    if (state_r == SEND) begin
      rd.rvalid = 1'b1;
      rd.rdata  = bank_r[idx_r];
      rd.raddr  = idx_r;
      rd.rlast  = (idx_r == LAST_IDX);
    end else begin
      rd.rvalid = 1'b0;
    end
  end

  assign arr_clr = arr_clr_r;
  assign busy    = (state_r != IDLE);
  assign ovr     = ovr_r;

endmodule

// File: tb/tb_result_drain.sv
// Directed bench for result_drain: reset, full drains, backpressure, snapshot
// isolation, overrun and mid-stream reset, checked with immediate assertions.
module tb_result_drain;

  logic        clk;
  logic        rst;
  logic        done;
  logic [32:0] c_arr [16];
  logic        arr_clr;
  logic        busy;
  logic        ovr;

  logic [32:0] exp_w [16];
  int          n_assert;
  int          n_fail;

  result_drain_if #(.DW(33)) rif ();

  result_drain #(.DW(33), .NW(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .done    (done),
    .c1      (c_arr[0]),
    .c2      (c_arr[1]),
    .c3      (c_arr[2]),
    .c4      (c_arr[3]),
    .c5      (c_arr[4]),
    .c6      (c_arr[5]),
    .c7      (c_arr[6]),
    .c8      (c_arr[7]),
    .c9      (c_arr[8]),
    .c10     (c_arr[9]),
    .c11     (c_arr[10]),
    .c12     (c_arr[11]),
    .c13     (c_arr[12]),
    .c14     (c_arr[13]),
    .c15     (c_arr[14]),
    .c16     (c_arr[15]),
    .rd      (rif.master),
    .arr_clr (arr_clr),
    .busy    (busy),
    .ovr     (ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_rvalid"}, {63'd0, rif.rvalid}, 64'd0);
    check({tag, "_rdata"},  {31'd0, rif.rdata},  64'd0);
    check({tag, "_raddr"},  {60'd0, rif.raddr},  64'd0);
    check({tag, "_rlast"},  {63'd0, rif.rlast},  64'd0);
    check({tag, "_busy"},   {63'd0, busy},       64'd0);
    check({tag, "_arrclr"}, {63'd0, arr_clr},    64'd0);
  endtask

  // Present base+k on c_k, pulse done for one posedge; returns in cycle N+1
  task automatic start_tile(input logic [32:0] base);
    @(negedge clk);
    for (int k = 0; k < 16; k++) begin
      c_arr[k] = base + 33'(k + 1);
      exp_w[k] = base + 33'(k + 1);
    end
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
  endtask

  // Drain words until stop_at handshakes; bp=1 gives rready 1,0,0,1,0,0...
  task automatic drain(input bit bp, input bit scramble, input int o1, input int o2,
                       input int stop_at);
    int  w;
    int  cyc;
    bit  hand;
    w   = 0;
    cyc = 0;
    while (w < stop_at && cyc < 100) begin
      check("rvalid", {63'd0, rif.rvalid}, 64'd1);
      check("busy",   {63'd0, busy},       64'd1);
      check("raddr",  {60'd0, rif.raddr},  64'(w));
      check("rdata",  {31'd0, rif.rdata},  {31'd0, exp_w[w]});
      check("rlast",  {63'd0, rif.rlast},  (w == 15) ? 64'd1 : 64'd0);
      check("arr_clr", {63'd0, arr_clr},   (cyc == 0) ? 64'd1 : 64'd0);
      if (bp) begin
        check("msb", {63'd0, rif.rdata[32]}, 64'd1);
      end
      rif.rready = bp ? ((cyc % 3) == 0) : 1'b1;
      if (scramble) begin
        for (int k = 0; k < 16; k++) c_arr[k] = 33'h0AAAAAAAA;
      end
      done = (w == o1 || w == o2);
      @(posedge clk);
      hand = rif.rready;
      @(negedge clk);
      done = 1'b0;
      rif.rready = 1'b1;
      if (hand) w++;
      cyc++;
    end
    check("drain_budget", 64'(w), 64'(stop_at));
    if (stop_at == 16) begin
      check_idle("post_drain");
    end
  endtask

  initial begin
    n_assert   = 0;
    n_fail     = 0;
    rst        = 1'b0;
    done       = 1'b1;
    rif.rready = 1'b1;
    for (int k = 0; k < 16; k++) c_arr[k] = 33'(k + 1);

    // Reset held with done high: nothing captured, outputs quiet
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    check("reset_ovr", {63'd0, ovr}, 64'd0);
    rst  = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_rvalid", {63'd0, rif.rvalid}, 64'd0);
      check("idle_busy",   {63'd0, busy},       64'd0);
    end

    // Basic drain c_k = k
    start_tile(33'd0);
    drain(1'b0, 1'b0, -1, -1, 16);
    check("basic_ovr", {63'd0, ovr}, 64'd0);

    // Backpressure with bit 32 set in every word
    start_tile(33'h100000000);
    drain(1'b1, 1'b0, -1, -1, 16);

    // Snapshot isolation against changing inputs
    start_tile(33'h012345670);
    drain(1'b0, 1'b1, -1, -1, 16);
    check("snap_ovr", {63'd0, ovr}, 64'd0);

    // Overrun at word 5 and on the final handshake
    start_tile(33'h000000100);
    drain(1'b0, 1'b0, 5, 15, 16);
    check("ovr_set", {63'd0, ovr}, 64'd1);
    start_tile(33'h0FFFFFF00);
    drain(1'b0, 1'b0, -1, -1, 16);
    check("ovr_sticky", {63'd0, ovr}, 64'd1);

    // Reset at word 7 discards the rest and clears ovr
    start_tile(33'h000000200);
    drain(1'b0, 1'b0, -1, -1, 7);
    check("pre_rst_raddr", {60'd0, rif.raddr}, 64'd7);
    rst = 1'b0;
    @(negedge clk);
    check_idle("mid_reset");
    check("mid_reset_ovr", {63'd0, ovr}, 64'd0);
    rst = 1'b1;
    start_tile(33'h1DEADBEE0);
    drain(1'b0, 1'b0, -1, -1, 16);
    check("final_ovr", {63'd0, ovr}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
